// File: rtl/mux_arb_pkg.sv
// Shared types and defaults for the two-requester round-robin selector arbiter.
package mux_arb_pkg;

   typedef enum logic [1:0] {IDLE, GNT1, GNT2} arb_state_t;
   typedef enum logic {OWNER1, OWNER2} owner_t;

   localparam int MUX_ARB_MAX_HOLD_DEF = 16;

endpackage

// File: rtl/mux_arb_hold_cnt.sv
// Grant hold counter: clears on grant entry, counts each granted cycle and saturates
// at MAX_HOLD-1, where term is raised.
module mux_arb_hold_cnt
   import mux_arb_pkg::*;
#(
   parameter int MAX_HOLD = MUX_ARB_MAX_HOLD_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic term
);

   localparam int CW = $clog2(MAX_HOLD + 1);
   localparam logic [CW-1:0] TERM_VAL = CW'(MAX_HOLD - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != TERM_VAL)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign term = (cnt_q == TERM_VAL);

endmodule

// File: rtl/mux_arb_2x1.sv
// Round-robin arbiter owning the 2:1 selector's select line (sel=1 routes a1, sel=0 routes a2).
// Optional owner timeout is built when MUX_ARB_TIMEOUT_EN is defined.
module mux_arb_2x1
   import mux_arb_pkg::*;
#(
   parameter int MAX_HOLD = MUX_ARB_MAX_HOLD_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req1,
   input  logic req2,
   output logic gnt1,
   output logic gnt2,
   output logic sel,
   output logic busy,
   output logic preempt
);

   if (MAX_HOLD < 2) begin : g_bad_max_hold
      $error("mux_arb_2x1: MAX_HOLD must be 2 or more");
   end

   arb_state_t state_q, state_d;
   owner_t     last_owner_q, last_owner_d;
   logic       sel_q, sel_d;

`ifdef MUX_ARB_TIMEOUT_EN
   logic hold_term;
   logic force_sw;
   logic preempt_q;
`endif

   always_comb begin
      state_d = state_q;
`ifdef MUX_ARB_TIMEOUT_EN
      force_sw = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (req1 && req2) begin
               state_d = (last_owner_q == OWNER1) ? GNT2 : GNT1;
            end else if (req1) begin
               state_d = GNT1;
            end else if (req2) begin
               state_d = GNT2;
            end
         end
         GNT1: begin
            if (req1) begin
`ifdef MUX_ARB_TIMEOUT_EN
               if (hold_term && req2) begin
                  state_d  = GNT2;
                  force_sw = 1'b1;
               end
`endif
            end else begin
               state_d = req2 ? GNT2 : IDLE;
            end
         end
         GNT2: begin
            if (req2) begin
`ifdef MUX_ARB_TIMEOUT_EN
               if (hold_term && req1) begin
                  state_d  = GNT1;
                  force_sw = 1'b1;
               end
`endif
            end else begin
               state_d = req1 ? GNT1 : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // sel only moves on a grant so the path stays put while idle
   always_comb begin
      last_owner_d = last_owner_q;
      sel_d        = sel_q;
      if (state_d == GNT1) begin
         last_owner_d = OWNER1;
         sel_d        = 1'b1;
      end else if (state_d == GNT2) begin
         last_owner_d = OWNER2;
         sel_d        = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_owner_q <= OWNER2;
         sel_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         sel_q        <= sel_d;
      end
   end

`ifdef MUX_ARB_TIMEOUT_EN
   mux_arb_hold_cnt #(
      .MAX_HOLD(MAX_HOLD)
   ) u_hold_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  ((state_d != state_q) && (state_d != IDLE)),
      .en   (state_q != IDLE),
      .term (hold_term)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         preempt_q <= 1'b0;
      end else begin
         preempt_q <= force_sw;
      end
   end

   assign preempt = preempt_q;
`else
   assign preempt = 1'b0;
`endif

   assign gnt1 = (state_q == GNT1);
   assign gnt2 = (state_q == GNT2);
   assign sel  = sel_q;
   assign busy = gnt1 | gnt2;

endmodule

// File: tb/tb_mux_arb_2x1.sv
// Directed bench for mux_arb_2x1 (MAX_HOLD=4); covers the timeout path when
// MUX_ARB_TIMEOUT_EN is defined and indefinite hold otherwise.
module tb_mux_arb_2x1;

   logic clk = 1'b0;
   logic rst_n;
   logic req1, req2;
   logic gnt1, gnt2, sel, busy, preempt;

   int checks   = 0;
   int failures = 0;

   mux_arb_2x1 #(
      .MAX_HOLD(4)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .req1   (req1),
      .req2   (req2),
      .gnt1   (gnt1),
      .gnt2   (gnt2),
      .sel    (sel),
      .busy   (busy),
      .preempt(preempt)
   );

   always #5 clk = ~clk;

   // expected vector order: {gnt1, gnt2, sel, busy, preempt}
   task automatic chk(input string tag, input logic [4:0] exp);
      logic [4:0] obs;
      obs = {gnt1, gnt2, sel, busy, preempt};
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed={g1,g2,sel,busy,pre}=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      req1  = 1'b1;
      req2  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_hold", 5'b00000);

      // release reset with both requesting: tie goes to requester 1
      rst_n = 1'b1;
      tick();
      chk("reset_tie_r1", 5'b10110);

      // handover without an idle bubble
      req1 = 1'b0;
      tick();
      chk("handover_1to2", 5'b01010);
      req2 = 1'b0;
      tick();
      chk("idle_sel_held0", 5'b00000);

      // single requester for 5 cycles
      req2 = 1'b1;
      tick();
      chk("single_r2_c0", 5'b01010);
      for (int i = 1; i < 5; i++) begin
         tick();
         chk($sformatf("single_r2_c%0d", i), 5'b01010);
      end
      req2 = 1'b0;
      tick();
      chk("single_r2_release", 5'b00000);

      // make requester 1 the last owner, then tie
      req1 = 1'b1;
      tick();
      chk("r1_grant", 5'b10110);
      req1 = 1'b0;
      tick();
      chk("idle_sel_held1", 5'b00100);
      req1 = 1'b1;
      req2 = 1'b1;
      tick();
      chk("rr_tie_r2_first", 5'b01010);
      req2 = 1'b0;
      tick();
      chk("rr_then_r1", 5'b10110);
      req1 = 1'b0;
      tick();
      chk("rr_idle", 5'b00100);

      // asynchronous reset during GNT2
      req2 = 1'b1;
      tick();
      chk("pre_reset_gnt2", 5'b01010);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_drop", 5'b00000);
      #1;
      rst_n = 1'b1;
      req1  = 1'b1;
      tick();
      chk("post_reset_tie_r1", 5'b10110);

      req1 = 1'b0;
      req2 = 1'b0;
      tick();
      chk("to_idle", 5'b00100);
      req1 = 1'b1;
      tick();
      chk("hold_c0", 5'b10110);
      tick();
      chk("hold_c1", 5'b10110);
      req2 = 1'b1;
`ifdef MUX_ARB_TIMEOUT_EN
      tick();
      chk("hold_c2", 5'b10110);
      tick();
      chk("hold_c3", 5'b10110);
      tick();
      chk("preempt_to_r2", 5'b01011);
      for (int i = 1; i < 4; i++) begin
         tick();
         chk($sformatf("r2_hold_c%0d", i), 5'b01010);
      end
      tick();
      chk("preempt_to_r1", 5'b10111);
      req2 = 1'b0;
      for (int i = 1; i < 7; i++) begin
         tick();
         chk($sformatf("saturate_c%0d", i), 5'b10110);
      end
      req2 = 1'b1;
      tick();
      chk("preempt_after_sat", 5'b01011);
      req1 = 1'b0;
      req2 = 1'b0;
      tick();
      chk("final_idle", 5'b00000);
`else
      for (int i = 2; i < 10; i++) begin
         tick();
         chk($sformatf("no_timeout_c%0d", i), 5'b10110);
      end
      req1 = 1'b0;
      tick();
      chk("late_handover", 5'b01010);
      req2 = 1'b0;
      tick();
      chk("final_idle", 5'b00000);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mux_arb_2x1.md
# mux_arb_2x1

Two-requester round-robin arbiter that owns the select line of the 2:1 selector in the datapath. It grants the shared output path to requester 1 (mux input `a1`) or requester 2 (mux input `a2`), and drives `sel` so that `sel=1` routes `a1` and `sel=0` routes `a2`. It sits directly in front of the selector and is the only agent allowed to change its select.

## Interface
- `MAX_HOLD`, 16: maximum consecutive grant cycles per owner while the other requester waits. Used only with `MUX_ARB_TIMEOUT_EN`. Legal values are 2 or more.
- `clk`  input  1  single clock, rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `req1`  input  1  requester 1 wants the path. Held high for the whole transfer.
- `req2`  input  1  requester 2 wants the path. Held high for the whole transfer.
- `gnt1`  output  1  requester 1 owns the path (registered).
- `gnt2`  output  1  requester 2 owns the path (registered).
- `sel`  output  1  selector control: 1 routes `a1`, 0 routes `a2` (registered).
- `busy`  output  1  `gnt1 | gnt2`.
- `preempt`  output  1  one-cycle pulse on a forced switch. Tied 0 without the macro.

## Operation
- Reset value of every output is 0. Reset also sets internal `last_owner` to 2, so requester 1 wins the first tie.
- The FSM has three states: IDLE, GNT1, GNT2. `gnt1`=(state==GNT1) and `gnt2`=(state==GNT2). `gnt1` and `gnt2` are never both high.
- IDLE transitions:
  - `req1&req2`: go to the state for the requester that is not `last_owner`.
  - Only `req1`: go to GNT1.
  - Only `req2`: go to GNT2.
  - Neither: stay in IDLE.
- GNTx, owner request still high: stay in GNTx. The owner is never preempted without the macro.
- GNTx, owner request low at the edge:
  - If the other request is high, go directly to GNTother. There is no IDLE bubble.
  - Otherwise go to IDLE.
- `last_owner` updates to x on every entry to GNTx.
- `sel`:
  - Set to 1 on entry to GNT1 and to 0 on entry to GNT2.
  - Holds its previous value in IDLE, so there is no spurious path change while idle.
- An owner's request asserted again in the same cycle as its release is treated as a new request and is subject to round-robin.

## Timing
- Grant latency from IDLE is 1 cycle: `req` sampled high at edge N gives `gnt`/`sel` valid after edge N.
- Release-to-handover is 1 cycle. At the edge where owner `req` is sampled low, the other grant rises and the old grant falls at the same edge.
- `sel` changes at the same edge as the grants. The downstream mux output is valid in the first cycle the grant is high.
- If `rst_n` is asserted mid-grant, all outputs drop to 0 immediately (asynchronously) and the FSM returns to IDLE. Deassertion is synchronized externally.

## Configuration
- `MUX_ARB_TIMEOUT_EN` defined:
  - A hold counter of width `$clog2(MAX_HOLD+1)` clears on every grant entry and increments each cycle in GNTx.
  - When the count equals `MAX_HOLD-1` and the other request is high, the next edge forces a move to GNTother and `preempt` pulses for 1 cycle.
  - A preempted owner keeps its request high and is re-granted by normal round-robin.
  - If the other request is low, the counter saturates and the owner keeps the grant.
- `MUX_ARB_TIMEOUT_EN` undefined: no counter, `preempt`=0, grants are held indefinitely.

## Structure
- Package `mux_arb_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, GNT1, GNT2} arb_state_t`
  - `typedef enum logic {OWNER1, OWNER2} owner_t`
  - `localparam int MUX_ARB_MAX_HOLD_DEF = 16`
- Sub-module `mux_arb_hold_cnt` (counter, clear, saturate, terminal flag) is instantiated only under `MUX_ARB_TIMEOUT_EN`.
- The existing 2:1 mux is not instantiated inside the arbiter. The integrating level connects `sel` to its `s`.

## Test plan
- Reset: hold `rst_n`=0 with `req1`=`req2`=1 → `gnt1`=`gnt2`=`sel`=`busy`=0. Release reset → after 1 edge `gnt1`=1, `sel`=1 (tie goes to requester 1).
- Single requester: `req2`=1 for 5 cycles, then 0 → `gnt2` high for exactly 5 cycles starting 1 edge after `req2`, `sel`=0, then IDLE with `sel` held at 0.
- Handover: `gnt1` active, `req2`=1, `req1` drops at edge N → `gnt1`=0 and `gnt2`=1 after edge N, with no IDLE cycle.
- Round-robin tie: in IDLE with `last_owner`=1, assert `req1`=`req2`=1 together → `gnt2` first. After `req2` drops, `gnt1`.
- Mid-grant reset: pulse `rst_n` low during GNT2 between edges → `gnt2`/`sel`/`busy` go to 0 without a clock edge, and the FSM is in IDLE afterwards.
- Timeout (macro on, `MAX_HOLD`=4): `req1` held, `req2` rises in cycle 1 of GNT1 → `gnt1` for 4 cycles, then `gnt2`=1 with `preempt`=1 for 1 cycle. With the macro off, `gnt1` is held indefinitely.
